// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared FSM state encoding, default parameters and truth-table width helper
package gate_chk_pkg;
  localparam int DEF_N_IN = 2;
  localparam int DEF_SETTLE = 1;
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/gate_chk_settle_timer.sv
// gate_chk_settle_timer: loadable down-counter with zero flag, times the settle window per vector
// Ports: clk, reset (sync, active-high), load/load_val (load has priority), en (decrement,
// stops at zero), cnt (current count), zero (cnt == 0).
module gate_chk_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps every minterm into a combinational gate and checks it against a truth table
// Ports: clk, reset (sync, active-high), start (accepted in IDLE only), expected (bit m = output
// for minterm m, latched at start), dut_in (vector to gate, MSB = input a), dut_out (gate output),
// busy (WAIT/SAMPLE), done (1-cycle pulse), pass, err_count, first_fail, fail_valid.
// Optional: define CAPTURE_TT_EN to add captured_tt, the truth table actually observed.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [tt_width(N_IN)-1:0]   expected,
  output logic [N_IN-1:0]             dut_in,
  input  logic                        dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_IN:0]               err_count,
  output logic [N_IN-1:0]             first_fail,
  output logic                        fail_valid
`ifdef CAPTURE_TT_EN
  ,
  output logic [tt_width(N_IN)-1:0]   captured_tt
`endif
);
  localparam int TT_W = tt_width(N_IN);
  localparam int SW = $clog2(SETTLE + 1);
  state_t state;
  logic [TT_W-1:0] tt_q;
  logic [N_IN-1:0] m;
  logic [SW-1:0] settle_cnt;
  logic settle_zero, settle_last, mismatch, last_m, accept, reload;
  assign dut_in = m;
  assign accept = state == IDLE && start;
  assign last_m = m == N_IN'(TT_W - 1);
  assign reload = accept || (state == SAMPLE && !last_m);
  assign mismatch = dut_out ^ tt_q[m];
  // zero only occurs for an out-of-range SETTLE of 0; treating it as expiry avoids a stall
  assign settle_last = settle_zero || settle_cnt == SW'(1);
  gate_chk_settle_timer #(.W(SW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (reload),
    .en       (state == WAIT),
    .load_val (SW'(SETTLE)),
    .cnt      (settle_cnt),
    .zero     (settle_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tt_q       <= '0;
      m          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= WAIT;
          tt_q       <= expected;
          m          <= '0;
          busy       <= 1'b1;
          pass       <= 1'b0;
          err_count  <= '0;
          first_fail <= '0;
          fail_valid <= 1'b0;
        end
        WAIT: if (settle_last) state <= SAMPLE;
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + (N_IN + 1)'(1);
            if (!fail_valid) begin
              first_fail <= m;
              fail_valid <= 1'b1;
            end
          end
          // pass folds in the final sample so it is already valid in the done cycle
          if (last_m) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_count == '0 && !mismatch;
          end else begin
            m     <= m + N_IN'(1);
            state <= WAIT;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
`ifdef CAPTURE_TT_EN
  always_ff @(posedge clk) begin
    if (reset || accept) captured_tt <= '0;
    else if (state == SAMPLE) captured_tt[m] <= dut_out;
  end
`endif
endmodule
